div_unit: RTL and testbench

//   Iterative radix-2 restoring divider in the EX stage for DIV/DIVU.

---
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit.sv | 171 +++++++++++++++++
 tb/tb_div_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// EX-stage divider request/response bundle: pipeline side drives the master view,
// the divider implements the slave view.
interface div_unit_if;
  logic        valid;
  logic [7:0]  aluop;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  modport master (
    output valid, aluop, dividend, divisor, cancel,
    input  stall, busy, done, quotient, remainder
  );

  modport slave (
    input  valid, aluop, dividend, divisor, cancel,
    output stall, busy, done, quotient, remainder
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: 35 cycles accept-to-done, stalls EX while busy.
// Define DIV_ZERO_FAST_EN to finish divide-by-zero one cycle after accept.
module div_unit #(
  parameter logic [7:0] DIV_OP  = 8'h1A,
  parameter logic [7:0] DIVU_OP = 8'h1B
) (
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        is_div;
  logic        accept;
  logic        divisor_zero;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        signed_div;
  logic        div_zero;
  logic        qneg;
  logic        rneg;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [4:0]  cnt;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] partial;
  logic        no_borrow;
  logic [31:0] rem_sub;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  logic [31:0] quotient_q;
  logic [31:0] remainder_q;

  assign is_div       = (bus.aluop == DIV_OP) | (bus.aluop == DIVU_OP);
  assign accept       = bus.valid & is_div & (state == S_IDLE) & ~bus.cancel;
  assign divisor_zero = (bus.divisor == 32'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          state_nxt = divisor_zero ? S_DONE : S_PREP;
`else
          state_nxt = S_PREP;
`endif
        end
      end
      S_PREP:  state_nxt = S_CALC;
      S_CALC:  if (cnt == 5'd31) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // A flush overrides every transition, including a coincident accept.
    if (bus.cancel) begin
      state_nxt = S_IDLE;
    end
  end

  always_comb begin
    a_neg = signed_div & op_a[31];
    b_neg = signed_div & op_b[31];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
  end

  // Shifting {rem,quo} left can push a 33rd bit into rem; the trial subtract covers it.
  always_comb begin
    partial   = {rem, quo[31]};
    no_borrow = (partial >= {1'b0, dvs});
    rem_sub   = partial[31:0] - dvs;
  end

  always_comb begin
    q_fix = qneg ? -quo : quo;
    r_fix = rneg ? -rem : rem;
    if (div_zero) begin
      q_fix = 32'hFFFF_FFFF;
      r_fix = op_a;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      signed_div <= 1'b0;
      div_zero   <= 1'b0;
      qneg       <= 1'b0;
      rneg       <= 1'b0;
      rem        <= 32'd0;
      quo        <= 32'd0;
      dvs        <= 32'd0;
      cnt        <= 5'd0;
    end else begin
      if (accept) begin
        op_a       <= bus.dividend;
        op_b       <= bus.divisor;
        signed_div <= (bus.aluop == DIV_OP);
        div_zero   <= divisor_zero;
      end
      unique case (state)
        S_PREP: begin
          quo  <= a_mag;
          dvs  <= b_mag;
          rem  <= 32'd0;
          cnt  <= 5'd0;
          qneg <= a_neg ^ b_neg;
          rneg <= a_neg;
        end
        S_CALC: begin
          rem <= no_borrow ? rem_sub : partial[31:0];
          quo <= {quo[30:0], no_borrow};
          cnt <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Results survive cancel; only a completed FIX (or the zero-divisor shortcut) loads them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
    end else if ((state == S_FIX) && !bus.cancel) begin
      quotient_q  <= q_fix;
      remainder_q <= r_fix;
    end
`ifdef DIV_ZERO_FAST_EN
    else if (accept && divisor_zero) begin
      quotient_q  <= 32'hFFFF_FFFF;
      remainder_q <= bus.dividend;
    end
`endif
  end

  assign bus.busy      = (state == S_PREP) | (state == S_CALC) | (state == S_FIX);
  assign bus.done      = (state == S_DONE);
  assign bus.stall     = (accept | bus.busy) & ~bus.cancel;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit: arithmetic reference model, randomized divides,
// cancel/reset/non-div corner cases.
module tb_div_unit;

  localparam logic [7:0] DIV_OP  = 8'h1A;
  localparam logic [7:0] DIVU_OP = 8'h1B;
`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit #(.DIV_OP(DIV_OP), .DIVU_OP(DIVU_OP)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_q = 32'd0;
  logic [31:0] last_r = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, with the zero-divisor rule.
  task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa, sb_, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op == DIVU_OP) begin
      q = a / b;
      r = a % b;
    end else begin
      sa  = $signed(a);
      sb_ = $signed(b);
      lq  = sa / sb_;
      lr  = sa % sb_;
      q   = lq[31:0];
      r   = lr[31:0];
    end
  endtask

  always @(negedge clk) begin
    if (resetn && bus.done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending divide (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", bus.quotient, mon_e.q);
        check("remainder", bus.remainder, mon_e.r);
        check("done_cycle", cyc, mon_e.due);
        last_q = mon_e.q;
        last_r = mon_e.r;
      end
    end
  end

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(1, 15);
      default: return $urandom;
    endcase
  endfunction

  // cancel_at > 0 aborts the divide in that cycle and expects no result.
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int cancel_at);
    logic [31:0] eq, er;
    int          lat;
    model(op, a, b, eq, er);
    lat = (FAST && (b == 32'd0)) ? 1 : 35;
    @(negedge clk);
    bus.valid    = 1'b1;
    bus.aluop    = op;
    bus.dividend = a;
    bus.divisor  = b;
    bus.cancel   = 1'b0;
    #1 check1("stall_accept", bus.stall, 1'b1);
    if (cancel_at == 0) sb.push_back('{eq, er, cyc + lat});
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == cancel_at) begin
        bus.valid  = 1'b0;
        bus.cancel = 1'b1;
        #1 check1("stall_cancel", bus.stall, 1'b0);
        @(negedge clk);
        bus.cancel = 1'b0;
        #1 check1("busy_after_cancel", bus.busy, 1'b0);
        return;
      end
      if (k < lat) begin
        // Requests arriving while busy must be ignored.
        bus.valid    = 1'($urandom_range(0, 1));
        bus.aluop    = $urandom_range(0, 1) ? DIV_OP : DIVU_OP;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
      end else begin
        bus.valid = 1'b0;
      end
      #1 check1("stall_run", bus.stall, k < lat);
    end
    bus.valid = 1'b0;
  endtask

  initial begin
    logic [7:0] op;
    bus.valid    = 1'b0;
    bus.aluop    = 8'h00;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    bus.cancel   = 1'b0;

    repeat (3) @(negedge clk);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_done", bus.done, 1'b0);
    check1("rst_stall", bus.stall, 1'b0);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    run_div(DIVU_OP, 32'd100, 32'd7, 0);
    run_div(DIV_OP, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(DIV_OP, 32'd7, 32'hFFFF_FFFE, 0);
    run_div(DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(DIVU_OP, 32'hFFFF_FFFF, 32'd1, 0);
    run_div(DIVU_OP, 32'd5, 32'd0, 0);
    run_div(DIV_OP, 32'h8000_0000, 32'd0, 0);

    run_div(DIVU_OP, 32'd1000, 32'd3, 10);
    repeat (40) @(negedge clk);
    check("q_retained", bus.quotient, last_q);
    check("r_retained", bus.remainder, last_r);
    run_div(DIVU_OP, 32'd9, 32'd3, 0);

    @(negedge clk);
    bus.valid  = 1'b1;
    bus.aluop  = DIV_OP;
    bus.cancel = 1'b1;
    #1 check1("stall_cancel_accept", bus.stall, 1'b0);
    @(negedge clk);
    bus.valid  = 1'b0;
    bus.cancel = 1'b0;
    #1 check1("busy_cancel_accept", bus.busy, 1'b0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do op = 8'($urandom); while (op == DIV_OP || op == DIVU_OP);
      @(negedge clk);
      bus.valid    = 1'b1;
      bus.aluop    = op;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
      #1 check1("stall_nondiv", bus.stall, 1'b0);
      @(negedge clk);
      bus.valid = 1'b0;
      #1 check1("busy_nondiv", bus.busy, 1'b0);
    end

    @(negedge clk);
    bus.valid    = 1'b1;
    bus.aluop    = DIV_OP;
    bus.dividend = 32'd12345;
    bus.divisor  = 32'd11;
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check1("midrst_busy", bus.busy, 1'b0);
    check1("midrst_done", bus.done, 1'b0);
    check("midrst_quotient", bus.quotient, 32'd0);
    check("midrst_remainder", bus.remainder, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    last_q = 32'd0;
    last_r = 32'd0;

    for (int i = 0; i < 60; i++) begin
      run_div($urandom_range(0, 1) ? DIV_OP : DIVU_OP, rnd_operand(), rnd_operand(), 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
